// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Receive-side FIFO behind a UART receiver. Synchronises the
//                receiver's frame-complete flag, captures each byte plus its
//                3-bit error flags, and presents the oldest entry through a
//                first-word-fall-through valid/pop interface with occupancy
//                and sticky overflow status.
//  Options     : UART_RX_FIFO_DROP_ERR_EN - when defined, frames carrying any
//                error flag are discarded and rd_err always reads 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter  int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             done_flag,
    input  logic [7:0]       data_in,
    input  logic [2:0]       error_in,
    input  logic             rd_pop,
    input  logic             clr_ovf,
    output logic             rd_valid,
    output logic [7:0]       rd_data,
    output logic [2:0]       rd_err,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] c_FULL_COUNT = CNT_W'(DEPTH);

    // Synchroniser and edge detector on the frame-complete flag
    logic r_sync1;
    logic r_sync2;
    logic r_sync3;
    logic w_push;

    // Staging register between edge detection and the storage array
    logic       r_stg_vld;
    logic [7:0] r_stg_data;
    logic [2:0] r_stg_err;
    logic       w_frame_ok;
    logic [2:0] w_err_keep;

    // Storage and pointers
    logic [10:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [10:0]      r_head;
    logic             r_overflow;

    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_wr_en;
    logic             w_drop;
    logic             w_nxt_nonempty;
    logic             w_bypass;

`ifdef UART_RX_FIFO_DROP_ERR_EN
    // Errored frames never enter the FIFO, so stored error bits are always 0
    assign w_frame_ok = (error_in == 3'b000);
    assign w_err_keep = 3'b000;
`else
    assign w_frame_ok = 1'b1;
    assign w_err_keep = error_in;
`endif

    assign w_push = r_sync2 & ~r_sync3;

    // Two-flop synchroniser plus a delay flop for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= done_flag;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // Capture the byte on the push pulse; data is stable while the flag is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stg_vld  <= 1'b0;
            r_stg_data <= 8'h00;
            r_stg_err  <= 3'b000;
        end else begin
            r_stg_vld <= w_push & w_frame_ok;
            if (w_push) begin
                r_stg_data <= data_in;
                r_stg_err  <= w_err_keep;
            end
        end
    end

    // Occupancy derives directly from the pointers, so status tracks them exactly
    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_full   = (w_count == c_FULL_COUNT);
    assign w_empty  = (r_wr_ptr == r_rd_ptr);

    // A pop only counts when an entry is present; a full FIFO still accepts a
    // write if the head leaves in the same cycle
    assign w_pop    = rd_pop & ~w_empty;
    assign w_wr_en  = r_stg_vld & (~w_full | w_pop);
    assign w_drop   = r_stg_vld & w_full & ~w_pop;

    assign w_wr_ptr_nxt   = r_wr_ptr + {{ADDR_W{1'b0}}, w_wr_en};
    assign w_rd_ptr_nxt   = r_rd_ptr + {{ADDR_W{1'b0}}, w_pop};
    assign w_nxt_nonempty = (w_wr_ptr_nxt != w_rd_ptr_nxt);

    // The next head is the word being written this cycle when the FIFO would
    // otherwise be empty; the array has not been updated yet, so forward it
    assign w_bypass = w_wr_en & (w_rd_ptr_nxt[ADDR_W-1:0] == r_wr_ptr[ADDR_W-1:0]);

    // Storage array write; contents are not reset, pointers define validity
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= {r_stg_err, r_stg_data};
        end
    end

    // Pointers, registered head word and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_head     <= 11'h000;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            if (w_nxt_nonempty) begin
                r_head <= w_bypass ? {r_stg_err, r_stg_data}
                                   : r_mem[w_rd_ptr_nxt[ADDR_W-1:0]];
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign rd_valid = ~w_empty;
    assign rd_data  = r_head[7:0];
    assign rd_err   = r_head[10:8];
    assign count    = w_count;
    assign full     = w_full;
    assign empty    = w_empty;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Self-checking bench for uart_rx_fifo. A queue-based model
//                tracks expected FIFO contents and status; a negedge monitor
//                compares the DUT against it every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic             done_flag;
    logic [7:0]       data_in;
    logic [2:0]       error_in;
    logic             rd_pop;
    logic             clr_ovf;
    logic             rd_valid;
    logic [7:0]       rd_data;
    logic [2:0]       rd_err;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             overflow;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .done_flag (done_flag),
        .data_in   (data_in),
        .error_in  (error_in),
        .rd_pop    (rd_pop),
        .clr_ovf   (clr_ovf),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_err    (rd_err),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a frame whose flag rise is sampled on edge N lands
    // in the FIFO on edge N+3. Pops are honoured only when non-empty.
    // ------------------------------------------------------------------
    typedef struct {
        int         land;
        logic [7:0] d;
        logic [2:0] e;
    } pend_t;

    pend_t       pend[$];
    logic [10:0] mq[$];
    logic        m_ovf;
    logic        m_prev_done;
    int          cyc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            pend.delete();
            m_ovf       = 1'b0;
            m_prev_done = 1'b0;
            cyc         = 0;
        end else begin
            logic set_ovf;
            set_ovf = 1'b0;
            cyc++;
            if (rd_pop && mq.size() > 0) void'(mq.pop_front());
            while (pend.size() > 0 && pend[0].land == cyc) begin
                pend_t p;
                p = pend.pop_front();
                if (mq.size() < DEPTH) mq.push_back({p.e, p.d});
                else set_ovf = 1'b1;
            end
            if (done_flag && !m_prev_done) begin
                pend_t p;
                p.land = cyc + 3;
                p.d    = data_in;
                p.e    = error_in;
`ifdef UART_RX_FIFO_DROP_ERR_EN
                if (error_in == 3'b000) pend.push_back(p);
`else
                pend.push_back(p);
`endif
            end
            m_prev_done = done_flag;
            if (set_ovf) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
        end
    end

    // Monitor: compare DUT status and head entry with the model each cycle
    always @(negedge clk) begin
        chk("mon_count", int'(count), mq.size());
        chk("mon_rd_valid", int'(rd_valid), int'(mq.size() > 0));
        chk("mon_full", int'(full), int'(mq.size() == DEPTH));
        chk("mon_empty", int'(empty), int'(mq.size() == 0));
        chk("mon_overflow", int'(overflow), int'(m_ovf));
        if (mq.size() > 0) begin
            chk("mon_rd_data", int'(rd_data), int'(mq[0][7:0]));
            chk("mon_rd_err", int'(rd_err), int'(mq[0][10:8]));
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic [2:0] e, input int hold);
        @(posedge clk); #1;
        data_in   = d;
        error_in  = e;
        done_flag = 1'b1;
        repeat (hold) @(posedge clk);
        #1 done_flag = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic pop_one();
        @(posedge clk); #1 rd_pop = 1'b1;
        @(posedge clk); #1 rd_pop = 1'b0;
    endtask

    initial begin
        done_flag = 1'b0;
        data_in   = 8'h00;
        error_in  = 3'b000;
        rd_pop    = 1'b0;
        clr_ovf   = 1'b0;
        rst_n     = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_rd_err", int'(rd_err), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_overflow", int'(overflow), 0);
        rst_n = 1'b1;

        // Three frames, then drain in order
        send_frame(8'h41, 3'b000, 3);
        send_frame(8'h42, 3'b000, 3);
        send_frame(8'h43, 3'b000, 3);
        @(negedge clk);
        chk("three_count", int'(count), 3);
        chk("three_head", int'(rd_data), 8'h41);
        repeat (3) pop_one();
        @(negedge clk);
        chk("three_empty", int'(empty), 1);

        // Latency: flag raised before edge N, entry visible only after N+3
        @(posedge clk); #1;
        data_in   = 8'h5A;
        error_in  = 3'b000;
        done_flag = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("lat_not_yet", int'(rd_valid), 0);
        @(posedge clk);
        #1 chk("lat_valid", int'(rd_valid), 1);
        chk("lat_data", int'(rd_data), 8'h5A);
        repeat (16) @(posedge clk);
        #1 chk("held_count", int'(count), 1);
        done_flag = 1'b0;
        repeat (3) @(posedge clk);
        pop_one();

        // Fill to DEPTH, then one more frame overflows
        for (int i = 0; i < DEPTH; i++) send_frame(8'(i), 3'b000, 1);
        send_frame(8'h99, 3'b000, 2);
        @(negedge clk);
        chk("ovf_full", int'(full), 1);
        chk("ovf_count", int'(count), DEPTH);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_head", int'(rd_data), 8'h00);
        @(posedge clk); #1 clr_ovf = 1'b1;
        @(posedge clk); #1 clr_ovf = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", int'(overflow), 0);

        // Push into a full FIFO in the same cycle as a pop
        @(posedge clk); #1;
        data_in   = 8'hAA;
        done_flag = 1'b1;
        repeat (2) @(posedge clk);
        @(posedge clk); #1 rd_pop = 1'b1;
        @(posedge clk); #1 rd_pop = 1'b0;
        done_flag = 1'b0;
        @(negedge clk);
        chk("fullpop_count", int'(count), DEPTH);
        chk("fullpop_ovf", int'(overflow), 0);
        repeat (DEPTH - 1) pop_one();
        @(negedge clk);
        chk("fullpop_last", int'(rd_data), 8'hAA);
        pop_one();
        repeat (3) @(posedge clk);

        // Frame with an error flag
        send_frame(8'h33, 3'b010, 3);
        @(negedge clk);
`ifdef UART_RX_FIFO_DROP_ERR_EN
        chk("err_dropped_count", int'(count), 0);
        chk("err_dropped_ovf", int'(overflow), 0);
`else
        chk("err_data", int'(rd_data), 8'h33);
        chk("err_flags", int'(rd_err), 3'b010);
`endif
        pop_one();

        // Randomised traffic with concurrent pops and overflow clears
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    send_frame(8'($urandom),
                               ($urandom % 4 == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
                               $urandom_range(1, 4));
                end
            end
            begin
                for (int j = 0; j < 600; j++) begin
                    @(posedge clk); #1;
                    rd_pop  = ($urandom % 4 == 0);
                    clr_ovf = ($urandom % 8 == 0);
                end
            end
        join
        rd_pop  = 1'b0;
        clr_ovf = 1'b0;
        repeat (DEPTH + 2) pop_one();

        // Reset in the middle of operation
        for (int i = 0; i < 5; i++) send_frame(8'hC0 + 8'(i), 3'b000, 2);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_empty", int'(empty), 1);
        chk("mid_rst_valid", int'(rd_valid), 0);
        chk("mid_rst_ovf", int'(overflow), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send_frame(8'h77, 3'b000, 3);
        @(negedge clk);
        chk("post_rst_valid", int'(rd_valid), 1);
        chk("post_rst_head", int'(rd_data), 8'h77);
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
